ibex_instr_mem_responder: RTL and testbench



---
 rtl/ibex_instr_mem_responder.sv | 99 +++++++++
 tb/tb_ibex_instr_mem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch memory responder: req/gnt handshake, fixed-latency in-order responses,
// bounded outstanding requests, and a side load port for preloading/patching the store.
module ibex_instr_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        instr_req_i,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    input  logic                        stall_i,
    input  logic                        load_we_i,
    input  logic [$clog2(MemWords)-1:0] load_addr_i,
    input  logic [31:0]                 load_wdata_i,
    output logic                        busy_o
);

    localparam int unsigned AW = $clog2(MemWords);
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);

    logic [31:0]          mem_q [MemWords];
    logic [AW-1:0]        word_idx;
    logic                 in_range;
    logic [31:0]          rd_data;
    logic                 unused_addr_lsbs;

    logic [CW-1:0]        out_q, out_d;
    logic [CW-1:0]        out_after_retire;
    logic                 slot_free;

    logic [RespLatency-1:0] vld_q;
    logic [RespLatency-1:0] err_q;
    logic [31:0]            data_q [RespLatency];

    assign word_idx         = instr_addr_i[AW+1:2];
    assign in_range         = (instr_addr_i[31:AW+2] == '0);
    assign rd_data          = mem_q[word_idx];
    assign unused_addr_lsbs = ^instr_addr_i[1:0];

    // A response retiring this cycle frees its slot for a same-cycle grant.
    assign out_after_retire = out_q - CW'(instr_rvalid_o);
    assign slot_free        = (out_after_retire < CW'(MaxOutstanding));
    assign instr_gnt_o      = instr_req_i & ~stall_i & slot_free & ~rst_i;

    // Store is deliberately left out of reset; loads are honoured even during reset.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem_q[load_addr_i] <= load_wdata_i;
        end
    end

    always_comb begin
        out_d = out_q;
        if (instr_gnt_o && !instr_rvalid_o) begin
            out_d = out_q + CW'(1);
        end else if (!instr_gnt_o && instr_rvalid_o) begin
            out_d = out_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    // Empty stages carry zero data so rdata/err are 0 whenever rvalid is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < RespLatency; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= instr_gnt_o;
            err_q[0]  <= instr_gnt_o & ~in_range;
            data_q[0] <= (instr_gnt_o && in_range) ? rd_data : 32'h0;
            for (int i = 1; i < RespLatency; i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign instr_rvalid_o = vld_q[RespLatency-1];
    assign instr_err_o    = err_q[RespLatency-1];
    assign instr_rdata_o  = data_q[RespLatency-1];
    assign busy_o         = (out_q != '0);

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Scoreboard bench: DUT A (latency 1, two outstanding) checked against a queue model,
// DUT B (latency 3, two outstanding) checked against a fixed per-cycle table.
module tb_ibex_instr_mem_responder;

    typedef struct packed {
        int          due;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqA, stallA, reqB, stallB;
    logic [31:0] addrA, addrB;
    logic        loadWe;
    logic [9:0]  loadAddr;
    logic [31:0] loadWdata;

    logic        gntA, rvA, errA, busyA;
    logic [31:0] rdataA;
    logic        gntB, rvB, errB, busyB;
    logic [31:0] rdataB;

    logic [31:0] memModel [1024];
    resp_t       sbQ [$];
    int          cyc = 0;
    int          checkCount = 0;
    int          errorCount = 0;
    int          bIdx = -1;
    logic        sawGntA;

    bit tblReqB  [15] = '{1,1,1,1,1,1,1,1,1,0,0,1,0,0,0};
    bit tblGntB  [15] = '{1,1,0,1,1,0,1,1,0,0,0,1,0,0,0};
    bit tblRvB   [15] = '{0,0,0,1,1,0,1,1,0,0,0,0,0,0,1};
    bit tblBusyB [15] = '{0,1,1,1,1,1,1,1,1,0,0,0,1,1,1};

    always #5 clk = ~clk;

    ibex_instr_mem_responder #(.MemWords(1024), .RespLatency(1), .MaxOutstanding(2)) dutA (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(reqA), .instr_addr_i(addrA), .instr_gnt_o(gntA),
        .instr_rvalid_o(rvA), .instr_rdata_o(rdataA), .instr_err_o(errA),
        .stall_i(stallA), .load_we_i(loadWe), .load_addr_i(loadAddr),
        .load_wdata_i(loadWdata), .busy_o(busyA)
    );

    ibex_instr_mem_responder #(.MemWords(1024), .RespLatency(3), .MaxOutstanding(2)) dutB (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(reqB), .instr_addr_i(addrB), .instr_gnt_o(gntB),
        .instr_rvalid_o(rvB), .instr_rdata_o(rdataB), .instr_err_o(errB),
        .stall_i(stallB), .load_we_i(loadWe), .load_addr_i(loadAddr),
        .load_wdata_i(loadWdata), .busy_o(busyB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic runCycle;
        logic  expRv, expGnt, oor;
        resp_t r;
        @(negedge clk);
        expRv  = (sbQ.size() != 0) && (sbQ[0].due == cyc);
        expGnt = reqA && !stallA && !rst && ((sbQ.size() - int'(expRv)) < 2);
        checkOutput("A_busy", 32'(busyA), 32'(sbQ.size() != 0));
        checkOutput("A_gnt", 32'(gntA), 32'(expGnt));
        checkOutput("A_rvalid", 32'(rvA), 32'(expRv));
        if (expRv) begin
            r = sbQ.pop_front();
            checkOutput("A_rdata", rdataA, r.data);
            checkOutput("A_err", 32'(errA), 32'(r.err));
        end else begin
            checkOutput("A_rdata_idle", rdataA, 32'h0);
            checkOutput("A_err_idle", 32'(errA), 32'h0);
        end
        sawGntA = gntA;
        if (expGnt) begin
            oor = (addrA[31:12] != 20'h0);
            r.due  = cyc + 1;
            r.err  = oor;
            r.data = oor ? 32'h0 : memModel[addrA[11:2]];
            sbQ.push_back(r);
        end
        if (bIdx >= 0) begin
            checkOutput("B_gnt", 32'(gntB), 32'(tblGntB[bIdx]));
            checkOutput("B_rvalid", 32'(rvB), 32'(tblRvB[bIdx]));
            checkOutput("B_busy", 32'(busyB), 32'(tblBusyB[bIdx]));
            checkOutput("B_rdata", rdataB, tblRvB[bIdx] ? ((bIdx == 14) ? 32'h22 : 32'h11) : 32'h0);
            checkOutput("B_err", 32'(errB), 32'h0);
        end
        @(posedge clk);
        cyc++;
        if (loadWe) memModel[loadAddr] = loadWdata;
        if (rst) sbQ.delete();
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic q, input logic [31:0] a, input logic s,
                                 input logic w, input logic [9:0] wa, input logic [31:0] wd);
        rst       = r;
        reqA      = q;
        addrA     = a;
        stallA    = s;
        loadWe    = w;
        loadAddr  = wa;
        loadWdata = wd;
        runCycle();
    endtask

    // Requester holds each address until granted; stall is high for stream cycles sFrom..sTo.
    task automatic fetchStream(input logic [31:0] base, input int n, input int sFrom, input int sTo);
        int i;
        int k;
        i = 0;
        k = 0;
        while (i < n && k < 50) begin
            applyStimulus(1'b0, 1'b1, base + 32'(4 * i), (k >= sFrom && k <= sTo), 1'b0, 10'h0, 32'h0);
            if (sawGntA) i++;
            k++;
        end
        checkOutput("A_stream_done", 32'(i), 32'(n));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] word;
        rst = 1'b1; reqA = 1'b0; addrA = '0; stallA = 1'b0;
        reqB = 1'b0; addrB = '0; stallB = 1'b0;
        loadWe = 1'b0; loadAddr = '0; loadWdata = '0;
        @(posedge clk);
        #1;

        // Preload the whole store while in reset; requests during reset must not be granted.
        for (int i = 0; i < 1024; i++) begin
            word = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
            if (i < 4) word = 32'(i + 1) * 32'h11;
            applyStimulus(1'b1, (i < 3), 32'h0, 1'b0, 1'b1, 10'(i), word);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);

        fetchStream(32'h0, 4, -1, -1);
        fetchStream(32'h40, 6, 2, 4);

        // Out-of-range and top-of-store fetches.
        applyStimulus(1'b0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 10'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0FFC, 1'b0, 1'b0, 10'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 10'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);

        // Load/fetch collision on word 5: old data first, patched data on the next fetch.
        applyStimulus(1'b0, 1'b1, 32'd20, 1'b0, 1'b1, 10'd5, 32'h0000_DEAD);
        applyStimulus(1'b0, 1'b1, 32'd20, 1'b0, 1'b0, 10'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkOutput("A_patched_word", memModel[5], 32'h0000_DEAD);

        // Latency-3 unit: grant pacing at the outstanding limit, then reset drops in-flight work.
        for (int k = 0; k < 15; k++) begin
            bIdx  = k;
            reqB  = tblReqB[k];
            addrB = (k == 11) ? 32'd4 : 32'd0;
            applyStimulus((k == 8), 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
        end
        bIdx = -1;
        reqB = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);

        checkOutput("A_queue_drained", 32'(sbQ.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
